// File: rtl/alu_exec_if.sv
// Operation/result handshake bundle between the issue stage and the execute-stage ALU.
interface alu_exec_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      alu_signal;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output in_valid, alu_signal, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_signal, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ops return 1 cycle after accept, shifts take shamt+1 via a serial shifter.
// A held result (out_ready low) blocks new accepts; draining and accepting happen on the same edge.
module alu_exec #(
  parameter int XLEN = 32
) (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave alu_io
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_e;

  state_e          state_q;
  shift_e          shop_q;
  logic [XLEN-1:0] shreg_q;
  logic [4:0]      cnt_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;

  logic            accept;
  logic            is_shift;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_d;
  logic [XLEN-1:0] shreg_d;
  shift_e          shop_d;

  assign alu_io.in_ready  = !rst && (state_q == IDLE || (state_q == DONE && alu_io.out_ready));
  assign accept           = alu_io.in_valid && alu_io.in_ready;
  assign shamt            = alu_io.op_b[4:0];
  assign alu_io.out_valid = (state_q == DONE);
  assign alu_io.result    = result_q;
  assign alu_io.zero      = zero_q;

  always_comb begin
    alu_d    = '0;
    is_shift = 1'b0;
    shop_d   = SH_SLL;
    case (alu_io.alu_signal)
      5'd0: alu_d = alu_io.op_a + alu_io.op_b;
      5'd1: alu_d = alu_io.op_a - alu_io.op_b;
      5'd3: alu_d = {{(XLEN-1){1'b0}}, ($signed(alu_io.op_a) < $signed(alu_io.op_b))};
      5'd4: alu_d = {{(XLEN-1){1'b0}}, (alu_io.op_a < alu_io.op_b)};
      5'd5: alu_d = alu_io.op_a ^ alu_io.op_b;
      5'd8: alu_d = alu_io.op_a | alu_io.op_b;
      5'd9: alu_d = alu_io.op_a & alu_io.op_b;
      // Shift result here only matters for a zero shift amount.
      5'd2: begin alu_d = alu_io.op_a; is_shift = 1'b1; shop_d = SH_SLL; end
      5'd6: begin alu_d = alu_io.op_a; is_shift = 1'b1; shop_d = SH_SRL; end
      5'd7: begin alu_d = alu_io.op_a; is_shift = 1'b1; shop_d = SH_SRA; end
      default: alu_d = '0;
    endcase
  end

  always_comb begin
    shreg_d = shreg_q;
    case (shop_q)
      SH_SLL:  shreg_d = {shreg_q[XLEN-2:0], 1'b0};
      SH_SRL:  shreg_d = {1'b0, shreg_q[XLEN-1:1]};
      SH_SRA:  shreg_d = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
      default: shreg_d = shreg_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shop_q   <= SH_SLL;
      shreg_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (is_shift) begin
              shreg_q <= alu_io.op_a;
              cnt_q   <= shamt;
              shop_q  <= shop_d;
            end
            if (is_shift && shamt != 5'd0) begin
              state_q <= SHIFT;
            end else begin
              state_q  <= DONE;
              result_q <= alu_d;
              zero_q   <= (alu_d == '0);
            end
          end else if (state_q == DONE && alu_io.out_ready) begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q  <= DONE;
            result_q <= shreg_d;
            zero_q   <= (shreg_d == '0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed vector bench for alu_exec: result, zero and latency per op, plus backpressure, streaming and reset corners.
module tb_alu_exec;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_exec_if #(.XLEN(32)) io ();

  alu_exec #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .alu_io (io)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[15];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents one op, waits for accept, then counts cycles until out_valid.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic z, output int lat, output int ir_hi);
    int t;
    io.in_valid   = 1'b1;
    io.alu_signal = op;
    io.op_a       = a;
    io.op_b       = b;
    t = 0;
    while (!io.in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) begin
      checks++; failures++;
      $display("FAIL accept_timeout: in_ready never rose for op %0d", op);
    end
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    lat   = 1;
    ir_hi = 0;
    while (!io.out_valid && lat < 100) begin
      if (io.in_ready) ir_hi++;
      @(posedge clk); #1;
      lat++;
    end
    res = io.result;
    z   = io.zero;
  endtask

  initial begin
    logic [31:0] res;
    logic        z;
    int          lat;
    int          ir_hi;
    logic [31:0] exp_stream[8];

    vecs[0]  = '{5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1};
    vecs[1]  = '{5'd1,  32'd5,        32'd5,        32'h00000000, 1'b1, 1};
    vecs[2]  = '{5'd3,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1};
    vecs[3]  = '{5'd4,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1};
    vecs[4]  = '{5'd5,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1};
    vecs[5]  = '{5'd8,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1};
    vecs[6]  = '{5'd9,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1};
    vecs[7]  = '{5'd15, 32'h00001234, 32'h00005678, 32'h00000000, 1'b1, 1};
    vecs[8]  = '{5'd7,  32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 32};
    vecs[9]  = '{5'd6,  32'h80000000, 32'd31,       32'h00000001, 1'b0, 32};
    vecs[10] = '{5'd2,  32'h00000001, 32'd0,        32'h00000001, 1'b0, 1};
    vecs[11] = '{5'd2,  32'h00000001, 32'd4,        32'h00000010, 1'b0, 5};
    vecs[12] = '{5'd6,  32'h00000080, 32'h00000108, 32'h00000000, 1'b1, 9};
    vecs[13] = '{5'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1};
    vecs[14] = '{5'd7,  32'h40000000, 32'd3,        32'h08000000, 1'b0, 4};

    rst           = 1'b1;
    io.in_valid   = 1'b0;
    io.out_ready  = 1'b1;
    io.alu_signal = '0;
    io.op_a       = '0;
    io.op_b       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'b0, io.in_ready},  32'd0);
    chk("rst_out_valid", {31'b0, io.out_valid}, 32'd0);
    chk("rst_result",    io.result,             32'd0);
    chk("rst_zero",      {31'b0, io.zero},      32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'b0, io.in_ready}, 32'd1);

    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat, ir_hi);
      chk($sformatf("vec%0d_result", i),  res,             vecs[i].res);
      chk($sformatf("vec%0d_zero", i),    {31'b0, z},      {31'b0, vecs[i].z});
      chk($sformatf("vec%0d_latency", i), lat,             vecs[i].lat);
      chk($sformatf("vec%0d_busy_rdy", i), ir_hi,          32'd0);
    end
    @(posedge clk); #1;

    // Backpressure: ADD 1+2 held while SUB 10-4 waits.
    io.out_ready = 1'b0;
    do_op(5'd0, 32'd1, 32'd2, res, z, lat, ir_hi);
    chk("bp_first_latency", lat, 32'd1);
    io.in_valid   = 1'b1;
    io.alu_signal = 5'd1;
    io.op_a       = 32'd10;
    io.op_b       = 32'd4;
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid",    {31'b0, io.out_valid}, 32'd1);
      chk("bp_hold_result",   io.result,             32'd3);
      chk("bp_hold_zero",     {31'b0, io.zero},      32'd0);
      chk("bp_hold_in_ready", {31'b0, io.in_ready},  32'd0);
      @(posedge clk); #1;
    end
    io.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'b0, io.in_ready}, 32'd1);
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    chk("bp_sub_valid",  {31'b0, io.out_valid}, 32'd1);
    chk("bp_sub_result", io.result,             32'd6);
    @(posedge clk); #1;
    chk("bp_drain_valid", {31'b0, io.out_valid}, 32'd0);

    // Stream of 8 single-cycle ops, one result per cycle.
    for (int i = 0; i < 8; i++)
      exp_stream[i] = (i % 2 == 0) ? 32'(3 * i + 7) : 32'(100 - i);
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        io.in_valid   = 1'b1;
        io.alu_signal = (i % 2 == 0) ? 5'd0 : 5'd1;
        io.op_a       = (i % 2 == 0) ? 32'(3 * i) : 32'd100;
        io.op_b       = (i % 2 == 0) ? 32'd7 : 32'(i);
        #1;
        chk($sformatf("stream%0d_in_ready", i), {31'b0, io.in_ready}, 32'd1);
      end else begin
        io.in_valid = 1'b0;
      end
      if (i > 0) begin
        chk($sformatf("stream%0d_valid", i - 1),  {31'b0, io.out_valid}, 32'd1);
        chk($sformatf("stream%0d_result", i - 1), io.result,             exp_stream[i - 1]);
      end
      @(posedge clk); #1;
    end
    chk("stream_end_valid", {31'b0, io.out_valid}, 32'd0);

    // Reset seven cycles into an SLL by 20.
    io.in_valid   = 1'b1;
    io.alu_signal = 5'd2;
    io.op_a       = 32'd1;
    io.op_b       = 32'd20;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      chk("rs_shift_in_ready", {31'b0, io.in_ready},  32'd0);
      chk("rs_shift_valid",    {31'b0, io.out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("rs_in_ready_low", {31'b0, io.in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rs_valid",  {31'b0, io.out_valid}, 32'd0);
    chk("rs_result", io.result,             32'd0);
    chk("rs_zero",   {31'b0, io.zero},      32'd0);
    repeat (25) begin
      @(posedge clk); #1;
      if (io.out_valid) chk("rs_no_stale_result", {31'b0, io.out_valid}, 32'd0);
    end
    do_op(5'd0, 32'd2, 32'd2, res, z, lat, ir_hi);
    chk("rs_add_result",  res,        32'd4);
    chk("rs_add_zero",    {31'b0, z}, 32'd0);
    chk("rs_add_latency", lat,        32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
